// File: rtl/mic_sequencer.sv
// mic_sequencer: Mic-1 microprogram sequencer.
//
// Each microinstruction takes two cycles. In LOAD the word at cs_addr (= mpc)
// is captured into MIR. In EXEC the MIR fields drive the datapath, and at the
// closing edge the ALU n/z flags are latched and the next MPC is formed. The
// next MPC is built by OR-ing bits in (JAMN/JAMZ/JMPC). It is never formed by
// incrementing.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cs_addr / cs_rdata    control store address out, combinational word in
//   n, z, mbr             live ALU flags and MBR byte for next-address forming
//   stall                 memory busy; holds the sequencer in LOAD
//   alu_ctrl, shift_ctrl  ungated MIR fields
//   c_we, mem_write, mem_read, mem_fetch, b_oe
//                         gated MIR fields, non-zero only in EXEC
//   flag_n, flag_z        latched flags (observation only)
//   mpc                   current micro-PC
//   halted                self-loop halt indication
//
// Optional feature: define MIC_SEQ_HALT_DETECT_EN to add a HALT state. The
// sequencer enters HALT when it executes an unconditional jump to itself.
// Without the macro, halted is tied to 0.
module mic_sequencer #(
    parameter int             CS_AW      = 9,
    parameter int             CS_DW      = 36,
    parameter int             MBR_W      = 8,
    parameter logic [CS_AW-1:0] RESET_ADDR = 9'h000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CS_AW-1:0] cs_addr,
    input  logic [CS_DW-1:0] cs_rdata,
    input  logic             n,
    input  logic             z,
    input  logic [MBR_W-1:0] mbr,
    input  logic             stall,
    output logic [5:0]       alu_ctrl,
    output logic [1:0]       shift_ctrl,
    output logic [8:0]       c_we,
    output logic             mem_write,
    output logic             mem_read,
    output logic             mem_fetch,
    output logic [8:0]       b_oe,
    output logic             flag_n,
    output logic             flag_z,
    output logic [CS_AW-1:0] mpc,
    output logic             halted
);

    typedef enum logic [1:0] {S_LOAD, S_EXEC, S_HALT} state_t;

    state_t           r_state;
    logic [CS_DW-1:0] r_mir;
    logic [CS_AW-1:0] r_mpc;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_halted;

    logic             w_exec;
    logic             w_jmpc;
    logic             w_jamn;
    logic             w_jamz;
    logic [CS_AW-1:0] w_next;
    logic [8:0]       w_b_dec;

    assign w_exec = (r_state == S_EXEC);
    assign w_jmpc = r_mir[26];
    assign w_jamn = r_mir[25];
    assign w_jamz = r_mir[24];

    // The high bit is forced by the live flags of this EXEC cycle.
    // The low byte is OR-ed with MBR for a JMPC dispatch.
    assign w_next[CS_AW-1]   = r_mir[35] | (w_jamn & n) | (w_jamz & z);
    assign w_next[CS_AW-2:0] = r_mir[34:27] | (w_jmpc ? mbr : {MBR_W{1'b0}});

    // One-hot B-bus driver select. Codes 9..15 select no driver.
    always_comb begin
        w_b_dec = 9'h000;
        if (r_mir[3:0] < 4'd9)
            w_b_dec = 9'h001 << r_mir[3:0];
    end

    assign cs_addr    = r_mpc;
    assign mpc        = r_mpc;
    assign flag_n     = r_flag_n;
    assign flag_z     = r_flag_z;
    assign halted     = r_halted;

    // The ALU and shifter are combinational. Leaving their controls live
    // during LOAD is harmless because no C-bus write is enabled then.
    assign alu_ctrl   = r_mir[21:16];
    assign shift_ctrl = r_mir[23:22];

    // Side-effecting fields are visible only in EXEC, so each one fires
    // exactly once per microinstruction.
    assign c_we       = w_exec ? r_mir[15:7] : 9'h000;
    assign mem_write  = w_exec & r_mir[6];
    assign mem_read   = w_exec & r_mir[5];
    assign mem_fetch  = w_exec & r_mir[4];
    assign b_oe       = w_exec ? w_b_dec : 9'h000;

`ifdef MIC_SEQ_HALT_DETECT_EN
    logic w_self_loop;
    assign w_self_loop = ~w_jmpc & ~w_jamn & ~w_jamz & (r_mir[35:27] == r_mpc);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_LOAD;
            r_mir    <= '0;
            r_mpc    <= RESET_ADDR;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (!stall) begin
                        r_mir   <= cs_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_flag_n <= n;
                    r_flag_z <= z;
                    r_mpc    <= w_next;
                    r_state  <= S_LOAD;
`ifdef MIC_SEQ_HALT_DETECT_EN
                    if (w_self_loop) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
`endif
                end
                S_HALT: begin
                    // Frozen until reset.
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_sequencer.sv
// tb_mic_sequencer: the stimulus process drives random flags, MBR, stall and
// reset. It runs a transaction-level reference model of the sequencer and
// pushes the expected outputs for every cycle into a queue. A monitor on the
// falling edge pops one entry per cycle and compares it with the DUT outputs.
module tb_mic_sequencer;

    logic        clk;
    logic        rst;
    logic [8:0]  cs_addr;
    logic [35:0] cs_rdata;
    logic        n, z;
    logic [7:0]  mbr;
    logic        stall;
    logic [5:0]  alu_ctrl;
    logic [1:0]  shift_ctrl;
    logic [8:0]  c_we;
    logic        mem_write, mem_read, mem_fetch;
    logic [8:0]  b_oe;
    logic        flag_n, flag_z;
    logic [8:0]  mpc;
    logic        halted;

    mic_sequencer dut (
        .clk(clk), .rst(rst), .cs_addr(cs_addr), .cs_rdata(cs_rdata),
        .n(n), .z(z), .mbr(mbr), .stall(stall),
        .alu_ctrl(alu_ctrl), .shift_ctrl(shift_ctrl), .c_we(c_we),
        .mem_write(mem_write), .mem_read(mem_read), .mem_fetch(mem_fetch),
        .b_oe(b_oe), .flag_n(flag_n), .flag_z(flag_z), .mpc(mpc),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control store model with a combinational read.
    logic [35:0] cs_mem [512];
    assign cs_rdata = cs_mem[cs_addr];

    typedef struct {
        logic [8:0] mpc;
        logic [5:0] alu;
        logic [1:0] sh;
        logic [8:0] cwe;
        logic [2:0] mem;
        logic [8:0] boe;
        logic       fn, fz, hl;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("mpc",        mpc,        e.mpc);
            chk("cs_addr",    cs_addr,    e.mpc);
            chk("alu_ctrl",   alu_ctrl,   e.alu);
            chk("shift_ctrl", shift_ctrl, e.sh);
            chk("c_we",       c_we,       e.cwe);
            chk("mem_wrf",    {mem_write, mem_read, mem_fetch}, e.mem);
            chk("b_oe",       b_oe,       e.boe);
            chk("flag_n",     flag_n,     e.fn);
            chk("flag_z",     flag_z,     e.fz);
            chk("halted",     halted,     e.hl);
        end
    end

    // Reference model state: phase 0 = fetch pending, 1 = executing, 2 = halted.
    logic [8:0]  m_mpc;
    logic [35:0] m_mir;
    int          m_ph;
    logic        m_fn, m_fz;
    bit          m_valid = 0;

    function automatic logic [35:0] mk(input logic [8:0] nxt, input logic jmpc,
                                       input logic jamn, input logic jamz,
                                       input logic [5:0] alu, input logic [8:0] c,
                                       input logic [2:0] wrf, input logic [3:0] b);
        return {nxt, jmpc, jamn, jamz, 2'b00, alu, c, wrf, b};
    endfunction

    // One clock cycle. Push the expected outputs of the current cycle, apply
    // the inputs, and advance the model across the coming edge.
    task automatic step(input logic r, input logic s, input logic nn,
                        input logic zz, input logic [7:0] mb);
        exp_t e;
        int   b;
        if (m_valid) begin
            b      = int'(m_mir[3:0]);
            e.mpc  = m_mpc;
            e.alu  = m_mir[21:16];
            e.sh   = m_mir[23:22];
            e.cwe  = (m_ph == 1) ? m_mir[15:7] : 9'h000;
            e.mem  = (m_ph == 1) ? m_mir[6:4]  : 3'b000;
            e.boe  = (m_ph == 1 && b <= 8) ? 9'(1 << b) : 9'h000;
            e.fn   = m_fn;
            e.fz   = m_fz;
            e.hl   = (m_ph == 2);
            q.push_back(e);
        end
        rst = r; stall = s; n = nn; z = zz; mbr = mb;
        if (r) begin
            m_mpc = 9'h000; m_mir = '0; m_ph = 0; m_fn = 0; m_fz = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_ph == 0) begin
                if (!s) begin
                    m_mir = cs_mem[m_mpc];
                    m_ph  = 1;
                end
            end else if (m_ph == 1) begin
                int hi, lo;
                logic [8:0] nxt;
                hi = int'(m_mir[35]) | (int'(m_mir[25]) & int'(nn)) | (int'(m_mir[24]) & int'(zz));
                lo = int'(m_mir[34:27]) | (m_mir[26] ? int'(mb) : 0);
                nxt = 9'(hi * 256 + lo);
                m_fn = nn; m_fz = zz;
                m_ph = 0;
`ifdef MIC_SEQ_HALT_DETECT_EN
                if (m_mir[26:24] == 3'b000 && m_mir[35:27] == m_mpc) m_ph = 2;
`endif
                m_mpc = nxt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rstep(input logic s);
        step(1'b0, s, 1'($urandom), 1'($urandom), 8'($urandom));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; n = 1'b0; z = 1'b0; mbr = 8'h00;

        // Directed image: 0 -> 5 -> 012/112 -> 100 -> MBR dispatch -> 020.
        // Address 020 jumps to itself.
        for (int i = 0; i < 512; i++)
            cs_mem[i] = mk(9'h020, 1'b0, 1'b0, 1'b0, 6'($urandom), 9'($urandom),
                           3'($urandom), 4'($urandom));
        cs_mem[9'h000] = mk(9'h005, 1'b0, 1'b0, 1'b0, 6'h3C, 9'h100, 3'b000, 4'h1);
        cs_mem[9'h005] = mk(9'h012, 1'b0, 1'b0, 1'b1, 6'h14, 9'h001, 3'b000, 4'hC);
        cs_mem[9'h012] = mk(9'h100, 1'b0, 1'b1, 1'b0, 6'h35, 9'h003, 3'b110, 4'h8);
        cs_mem[9'h112] = mk(9'h100, 1'b0, 1'b1, 1'b0, 6'h35, 9'h003, 3'b110, 4'h8);
        cs_mem[9'h100] = mk(9'h000, 1'b1, 1'b0, 1'b0, 6'h18, 9'h080, 3'b001, 4'h2);
        cs_mem[9'h020] = mk(9'h020, 1'b0, 1'b0, 1'b0, 6'h3C, 9'h100, 3'b000, 4'h0);

        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Hold in LOAD for three cycles, then run the directed chain.
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 40; i++) rstep(($urandom % 4) == 0);
        // Deterministic pass that exercises JAMZ with z=1, JAMN with n=1 and
        // JMPC to A7. Address 0A7 leads to the self-loop.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'hA7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'hA7);

        // Random control store with random inputs and occasional resets,
        // some of which land in the middle of EXEC.
        for (int i = 0; i < 512; i++)
            cs_mem[i] = {4'($urandom), 32'($urandom)};
        for (int blk = 0; blk < 12; blk++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            for (int i = 0; i < 150; i++) begin
                if (($urandom % 97) == 0)
                    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                else
                    rstep(($urandom % 3) == 0);
            end
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mic_sequencer.md
Name: mic_sequencer

Overview:
- Microprogram sequencer for the Mic-1 datapath; sits directly upstream of the ALU.
- Fetches 36-bit microinstructions from an external control store into MIR.
- Drives ALU control, shifter control, B-bus select, C-bus write enables and memory commands.
- Latches the ALU n/z outputs and computes the next MPC (JAMN/JAMZ/JMPC).
- Two clock cycles per microinstruction: LOAD, then EXEC.

Parameters:
CS_AW, 9, control store address width (MPC width)
CS_DW, 36, control store word width
MBR_W, 8, MBR width used for the JMPC OR
RESET_ADDR, 9'h000, MPC value after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
cs_addr  output  CS_AW  control store address; combinationally equal to mpc
cs_rdata  input  CS_DW  control store word; combinational read of cs_addr
n  input  1  ALU negative flag
z  input  1  ALU zero flag
mbr  input  MBR_W  MBR contents for JMPC
stall  input  1  memory busy; holds the sequencer in LOAD
alu_ctrl  output  6  {F0,F1,ENA,ENB,INVA,INC} = mir[21:16]
shift_ctrl  output  2  {SLL8,SRA1} = mir[23:22]
c_we  output  9  {H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR} = mir[15:7]; gated
mem_write  output  1  mir[6]; gated
mem_read  output  1  mir[5]; gated
mem_fetch  output  1  mir[4]; gated
b_oe  output  9  one-hot B-bus driver enable decoded from mir[3:0]; gated
flag_n  output  1  latched N
flag_z  output  1  latched Z
mpc  output  CS_AW  current micro-PC
halted  output  1  halt indication (see Optional Feature)

Behaviour:
- MIR layout: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:22] shift, [21:16] ALU, [15:7] C, [6:4] WRITE/READ/FETCH, [3:0] B.
- Reset (rst=1 at an edge; dominates all other inputs):
  - mpc=RESET_ADDR, mir=0, state=LOAD.
  - flag_n=0, flag_z=0, halted=0.
  - All gated outputs are 0.
  - alu_ctrl=6'h00 and shift_ctrl=0 from mir=0.
  - A reset in mid-EXEC abandons the microinstruction; no flags or mpc update.
- State LOAD:
  - Gated outputs forced to 0.
  - If stall=1: stay in LOAD with mir, mpc and flags unchanged.
  - Else: mir <= cs_rdata, go to EXEC.
- State EXEC:
  - Gated outputs reflect mir.
  - c_we, mem_* and b_oe are active for exactly one cycle per microinstruction.
  - stall is ignored.
  - At the closing edge: flag_n <= n, flag_z <= z, mpc <= next, go to LOAD.
- Next address:
  - next[8] = mir[35] | (JAMN & n) | (JAMZ & z).
  - next[7:0] = mir[34:27] | (JMPC ? mbr : 8'h00).
  - JAMN/JAMZ use the live n/z from the same EXEC cycle, not the latched flags.
  - flag_n/flag_z are visible outputs only.
- b_oe decode: 0=MDR, 1=PC, 2=MBR, 3=MBRU, 4=SP, 5=LV, 6=CPP, 7=TOS, 8=OPC (bit i set for code i). Codes 9–15 give b_oe=0.
- alu_ctrl and shift_ctrl are ungated; they hold mir during LOAD. The ALU is combinational, so this is harmless because no C write is enabled.
- Wrap-around: mpc arithmetic is pure OR, never increment; mpc 9'h1FF is legal.

Optional Feature:
- Macro: MIC_SEQ_HALT_DETECT_EN.
- Defined:
  - In EXEC, if JMPC=JAMN=JAMZ=0 and NEXT_ADDRESS==mpc, enter state HALT at the closing edge; flags still update.
  - HALT: halted=1, gated outputs 0, mir/mpc/flags frozen, stall ignored.
  - Only rst leaves HALT.
- Undefined:
  - No HALT state exists; halted is tied to 0.
  - A self-loop executes repeatedly as LOAD/EXEC pairs.

Test Plan:
- Reset then release, cs word at 0 = {NEXT=9'h005, ALU=6'h3C, C=H, B=1} -> cycle 1 LOAD with c_we=0, cycle 2 EXEC with alu_ctrl=6'h3C, c_we=9'h100, b_oe=9'h002; mpc=9'h005 after.
- Hold stall=1 for 3 cycles in LOAD -> mir, mpc unchanged, all gated outputs 0 throughout; EXEC starts the cycle after stall drops.
- JAMZ=1, NEXT=9'h012, drive z=1, n=0 in EXEC -> mpc=9'h112, flag_z=1; repeat with z=0 -> mpc=9'h012, flag_z=0.
- JAMN=1, NEXT=9'h100, n=1 -> mpc=9'h100 (bit already set, no change); JMPC=1, NEXT=9'h000, mbr=8'hA7 -> mpc=9'h0A7.
- B field 4'hC -> b_oe=0; B field 4'h8 -> b_oe=9'h100; WRITE|READ set -> mem_write=mem_read=1 for exactly one cycle.
- With MIC_SEQ_HALT_DETECT_EN, mpc=9'h020 holds NEXT=9'h020, no jams -> halted=1 from the next cycle and stays 1 for 10 cycles; rst returns mpc=RESET_ADDR, halted=0. Without the macro -> halted stays 0 and c_we pulses every second cycle.
